// File: rtl/sha256_compress_if.sv
// Round-engine port bundle: start/chaining value in, W/K from the schedule stage,
// round index back upstream, digest with a done pulse out.
interface sha256_compress_if;
    logic         start;
    logic [255:0] hash_in;
    logic [31:0]  W;
    logic [31:0]  K;
    logic [5:0]   count;
    logic         busy;
    logic         done;
    logic [255:0] digest;

    modport master (
        output start, hash_in, W, K,
        input  count, busy, done, digest
    );

    modport slave (
        input  start, hash_in, W, K,
        output count, busy, done, digest
    );
endinterface

// File: rtl/sha256_compress.sv
// SHA-256 compression: 64 rounds at one per clock, start-to-done latency 65 cycles.
// No backpressure: start is ignored while busy, W/K must be valid every round cycle.
module sha256_compress (
    input  logic             clk,
    input  logic             reset,
    sha256_compress_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t       state;
    state_t       state_nx;
    logic         load;
    logic         round;
    logic         fin;
    logic [31:0]  wv [8];
    logic [31:0]  hv [8];
    logic [5:0]   count_q;
    logic         done_q;
    logic [255:0] digest_q;
    logic [31:0]  t1;
    logic [31:0]  t2;

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    assign t1 = wv[7] + bsig1(wv[4]) + ch(wv[4], wv[5], wv[6]) + bus.K + bus.W;
    assign t2 = bsig0(wv[0]) + maj(wv[0], wv[1], wv[2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        round    = 1'b0;
        fin      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load     = 1'b1;
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                round = 1'b1;
                if (count_q == 6'd63) begin
                    state_nx = FINAL;
                end
            end
            FINAL: begin
                fin      = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Working words a..h live in wv[0..7]; the chaining value is kept in hv for the final add.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                wv[i] <= '0;
                hv[i] <= '0;
            end
            count_q  <= '0;
            done_q   <= 1'b0;
            digest_q <= '0;
        end else begin
            done_q <= fin;
            if (load) begin
                for (int i = 0; i < 8; i++) begin
                    wv[i] <= bus.hash_in[255 - 32*i -: 32];
                    hv[i] <= bus.hash_in[255 - 32*i -: 32];
                end
                count_q <= '0;
            end else if (round) begin
                wv[7]   <= wv[6];
                wv[6]   <= wv[5];
                wv[5]   <= wv[4];
                wv[4]   <= wv[3] + t1;
                wv[3]   <= wv[2];
                wv[2]   <= wv[1];
                wv[1]   <= wv[0];
                wv[0]   <= t1 + t2;
                count_q <= (count_q == 6'd63) ? 6'd0 : count_q + 6'd1;
            end
            if (fin) begin
                for (int i = 0; i < 8; i++) begin
                    digest_q[255 - 32*i -: 32] <= hv[i] + wv[i];
                end
            end
        end
    end

    assign bus.count  = count_q;
    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.digest = digest_q;
endmodule
